// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the decoder state encoding.
package gray_pkg;

  localparam int unsigned FN_W = 32;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  // Each binary bit is the XOR of all Gray bits at or above it; zero-extension keeps this width-agnostic.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(FN_W); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-bit two-flop synchroniser; only safe for buses that change one bit at a time (Gray code).
module gray_sync #(
  parameter int unsigned BITS = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] async_bus,
  output logic [BITS-1:0] sync_bus
);

  logic [BITS-1:0] sync1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync_bus <= '0;
    end else begin
      sync1    <= async_bus;
      sync_bus <= sync1;
    end
  end

endmodule

// File: rtl/gray_count_decoder.sv
// Loopback checker for a Gray-coded counter: synchronise, decode, classify steps, track lock and errors.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int unsigned BITS          = 5,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BITS-1:0]  gray_in,
  output logic [BITS-1:0]  bin_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             wrap,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [BITS-1:0]  MAX_VAL  = '1;

  logic [BITS-1:0]  sync2;
  logic [BITS-1:0]  cur_bin;
  logic [BITS-1:0]  cur_d;
  logic [1:0]       warm;
  logic [BITS-1:0]  prev_bin;
  logic [CNT_W-1:0] stable_cnt;
  state_t           state;

  state_t           state_next;
  logic [CNT_W-1:0] stable_cnt_next;
  logic [BITS-1:0]  prev_bin_next;
  logic [BITS-1:0]  bin_out_next;
  logic             bin_valid_next;
  logic             dir_up_next;
  logic             wrap_next;
  logic             err_next;
  logic [ERR_W-1:0] err_count_next;
  logic [BITS-1:0]  step_up;
  logic [BITS-1:0]  step_dn;

  gray_sync #(.BITS(BITS)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_bus (gray_in),
    .sync_bus  (sync2)
  );

  assign step_up = prev_bin + BITS'(1);
  assign step_dn = prev_bin - BITS'(1);

  // Decode pipeline; warm blocks stability counting until cur_d holds a post-reset sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_bin <= '0;
      cur_d   <= '0;
      warm    <= '0;
    end else begin
      cur_bin <= BITS'(gray2bin(FN_W'(sync2)));
      cur_d   <= cur_bin;
      warm    <= (warm == 2'd3) ? warm : warm + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACQUIRE;
      stable_cnt <= '0;
      prev_bin   <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      dir_up     <= 1'b1;
      wrap       <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_cnt_next;
      prev_bin   <= prev_bin_next;
      bin_out    <= bin_out_next;
      bin_valid  <= bin_valid_next;
      dir_up     <= dir_up_next;
      wrap       <= wrap_next;
      locked     <= (state_next == TRACK);
      err        <= err_next;
      err_count  <= err_count_next;
    end
  end

  // Up-step is tested first so that with BITS=1 every change reads as +1.
  always_comb begin
    state_next      = state;
    stable_cnt_next = stable_cnt;
    prev_bin_next   = prev_bin;
    bin_out_next    = bin_out;
    bin_valid_next  = 1'b0;
    dir_up_next     = dir_up;
    wrap_next       = 1'b0;
    err_next        = 1'b0;
    err_count_next  = err_count;

    case (state)
      ACQUIRE: begin
        if (warm == 2'd3) begin
          if (cur_bin == cur_d) begin
            stable_cnt_next = (stable_cnt >= STABLE_N) ? stable_cnt : stable_cnt + CNT_W'(1);
          end else begin
            stable_cnt_next = CNT_W'(1);
          end
          if (stable_cnt_next >= STABLE_N) begin
            state_next     = TRACK;
            prev_bin_next  = cur_bin;
            bin_out_next   = cur_bin;
            bin_valid_next = 1'b1;
          end
        end
      end
      TRACK: begin
        if (cur_bin == step_up) begin
          prev_bin_next  = cur_bin;
          bin_out_next   = cur_bin;
          bin_valid_next = 1'b1;
          dir_up_next    = 1'b1;
          wrap_next      = (prev_bin == MAX_VAL);
        end else if (cur_bin == step_dn) begin
          prev_bin_next  = cur_bin;
          bin_out_next   = cur_bin;
          bin_valid_next = 1'b1;
          dir_up_next    = 1'b0;
          wrap_next      = (prev_bin == '0);
        end else if (cur_bin != prev_bin) begin
          err_next        = 1'b1;
          err_count_next  = (err_count == '1) ? err_count : err_count + ERR_W'(1);
          state_next      = ACQUIRE;
          stable_cnt_next = CNT_W'(1);
        end
      end
      default: state_next = ACQUIRE;
    endcase
  end

endmodule
